mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum consecutive cycles with mem_ready low in FETCH or MEM before abort (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 The block SHALL have port ir, input, 32, instruction register contents; valid from DECODE onward.
REQ-005 The block SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-006 The block SHALL have port br_taken, input, 1, branch comparator result; sampled in EXEC.
REQ-007 The block SHALL have outputs mem_req, mem_we, ir_we, pc_we, rf_we, each 1 bit: memory request, memory write, IR load, PC load, register-file write.
REQ-008 The block SHALL have output imm_sel, 7 bits, opcode select driven to the immediate generator.
REQ-009 The block SHALL have outputs alu_a_pc and alu_b_imm, each 1 bit: ALU A = PC, and ALU B = immediate.
REQ-010 The block SHALL have output pc_sel, 2 bits: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
REQ-011 The block SHALL have output wb_sel, 2 bits: 0 = ALU, 1 = memory data, 2 = PC+4.
REQ-012 The block SHALL have outputs state, 3 bits, current state; halt, 1 bit; err, 2 bits: 0 = none, 1 = illegal opcode, 2 = timeout.

Function
REQ-013 The block SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and HALT=5.
REQ-014 In FETCH the block SHALL assert mem_req with mem_we=0; on mem_ready=1 it SHALL pulse ir_we and go to DECODE, otherwise it SHALL stay in FETCH.
REQ-015 In DECODE the block SHALL register opcode=ir[6:0] and hold it as imm_sel until the next DECODE.
REQ-016 In DECODE, if opcode is not one of OP, OPIMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL or JALR, the block SHALL go to HALT with err=1; otherwise it SHALL go to EXEC.
REQ-017 In EXEC, alu_b_imm SHALL be 1 for every opcode except OP and BRANCH, and alu_a_pc SHALL be 1 for AUIPC only.
REQ-018 From EXEC, LOAD and STORE SHALL go to MEM; OP, OPIMM, LUI, AUIPC, JAL and JALR SHALL go to WB.
REQ-019 From EXEC, BRANCH SHALL pulse pc_we with pc_sel = br_taken ? 1 : 0 and go to FETCH.
REQ-020 In MEM the block SHALL assert mem_req with mem_we=1 for STORE and mem_we=0 for LOAD.
REQ-021 In MEM, on mem_ready=1, LOAD SHALL go to WB, and STORE SHALL pulse pc_we with pc_sel=0 and go to FETCH.
REQ-022 In WB the block SHALL pulse rf_we and pc_we and go to FETCH, with wb_sel = 1 for LOAD, 2 for JAL/JALR, else 0.
REQ-023 In WB, pc_sel SHALL be 1 for JAL, 2 for JALR, else 0.
REQ-024 Writes to rd=0 SHALL NOT be suppressed here; the register file ignores them.
REQ-025 Outputs SHALL be combinational from state, the registered opcode, mem_ready and br_taken; pc_we, rf_we and ir_we SHALL be high for at most one cycle per instruction.
REQ-026 Latency with zero-wait memory SHALL be 3 cycles for BRANCH, 4 for OP/OPIMM/LUI/AUIPC/JAL/JALR/STORE, and 5 for LOAD; each wait cycle adds 1.
REQ-027 An 8-bit wait counter SHALL increment each cycle in FETCH or MEM while mem_ready=0, and SHALL clear on state change or on mem_ready=1.
REQ-028 When the wait counter reaches TIMEOUT the block SHALL go to HALT with err=2; mem_ready=1 in that same cycle SHALL win, completing the access normally.
REQ-029 In HALT, halt SHALL be 1, all enables and mem_req SHALL be 0, and err SHALL hold; only rst exits HALT.

Reset
REQ-030 On rst=1 the block SHALL immediately go to state FETCH, regardless of clk.
REQ-031 On rst=1, opcode and the wait counter SHALL reset to 0, and err and halt SHALL reset to 0.
REQ-032 During reset all write enables SHALL be 0, and mem_req SHALL deassert combinationally; a reset mid-access SHALL abort it with no pc_we or rf_we.
REQ-033 On the first rising clk edge after rst falls, the block SHALL be in FETCH with mem_req=1.

Configuration
REQ-034 With macro MC_INSTRET_EN defined, the block SHALL add output instret, 32 bits, reset to 0, incremented on every cycle pc_we=1 and wrapping from 0xFFFFFFFF to 0.
REQ-035 Without MC_INSTRET_EN, port instret and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-036 Zero-wait memory with ir=0x00500093 (addi) SHALL visit states 0,1,2,4,0, assert rf_we in cycle 4 with wb_sel=0 and imm_sel=0x13.
REQ-037 ir=0x0000A103 (lw) with mem_ready low for 3 MEM cycles SHALL complete in 8 cycles, with rf_we and wb_sel=1 in the final cycle.
REQ-038 ir=0x00000463 (beq) with br_taken=1 SHALL pulse pc_we with pc_sel=1 in cycle 3 and SHALL NOT assert rf_we.
REQ-039 ir=0xFFFFFFFF SHALL give halt=1 and err=1 after DECODE, and SHALL keep halt=1 for 20 more cycles until rst.
REQ-040 mem_ready held 0 in FETCH with TIMEOUT=15 SHALL enter HALT with err=2 after 15 wait cycles, and an rst pulse SHALL return the block to FETCH with err=0.
REQ-041 rst asserted mid-MEM of a sw SHALL drop mem_req in the same cycle with no pc_we; with MC_INSTRET_EN, instret SHALL increment by exactly 1 per completed instruction.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with memory wait timeout.
// Optional retired-instruction counter enabled by defining MC_INSTRET_EN.
module mc_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [6:0]  imm_sel,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        halt,
    output logic [1:0]  err
`ifdef MC_INSTRET_EN
   ,output logic [31:0] instret
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    state_t      cur, nxt;
    logic [6:0]  opcode;
    logic [7:0]  wait_cnt, wait_nxt;
    logic [1:0]  err_q, err_nxt;
    logic        legal;
    logic        timeout;
    logic        ir_unused;

    assign ir_unused = ^ir[31:7];

    always_comb begin
        legal = 1'b0;
        case (ir[6:0])
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_LOAD,
            OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // A ready in the cycle the limit is reached still completes the access
    assign timeout = (wait_cnt == 8'(TIMEOUT)) && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= FETCH;
            opcode   <= 7'd0;
            wait_cnt <= 8'd0;
            err_q    <= 2'd0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            err_q    <= err_nxt;
            if (cur == DECODE)
                opcode <= ir[6:0];
        end
    end

    always_comb begin
        nxt     = cur;
        err_nxt = err_q;
        case (cur)
            FETCH: begin
                if (mem_ready) nxt = DECODE;
                else if (timeout) begin
                    nxt     = HALT;
                    err_nxt = 2'd2;
                end
            end
            DECODE: begin
                if (legal) nxt = EXEC;
                else begin
                    nxt     = HALT;
                    err_nxt = 2'd1;
                end
            end
            EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) nxt = MEM;
                else if (opcode == OP_BRANCH) nxt = FETCH;
                else nxt = WB;
            end
            MEM: begin
                if (mem_ready) nxt = (opcode == OP_LOAD) ? WB : FETCH;
                else if (timeout) begin
                    nxt     = HALT;
                    err_nxt = 2'd2;
                end
            end
            WB:      nxt = FETCH;
            HALT:    nxt = HALT;
            default: nxt = FETCH;
        endcase
        wait_nxt = 8'd0;
        if ((cur == FETCH || cur == MEM) && !mem_ready && nxt == cur)
            wait_nxt = wait_cnt + 8'd1;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        alu_a_pc  = 1'b0;
        alu_b_imm = 1'b0;
        pc_sel    = 2'd0;
        wb_sel    = 2'd0;
        // Reset kills any access in flight without waiting for a clock
        if (!rst) begin
            case (cur)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                EXEC: begin
                    alu_a_pc  = (opcode == OP_AUIPC);
                    alu_b_imm = (opcode != OP_OP) && (opcode != OP_BRANCH);
                    if (opcode == OP_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? 2'd1 : 2'd0;
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (opcode == OP_STORE);
                    pc_we   = mem_ready && (opcode == OP_STORE);
                end
                WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    if (opcode == OP_LOAD) wb_sel = 2'd1;
                    else if (opcode == OP_JAL || opcode == OP_JALR) wb_sel = 2'd2;
                    if (opcode == OP_JAL) pc_sel = 2'd1;
                    else if (opcode == OP_JALR) pc_sel = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign state   = cur;
    assign halt    = (cur == HALT);
    assign err     = err_q;
    assign imm_sel = opcode;

`ifdef MC_INSTRET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret <= 32'd0;
        else if (pc_we) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        mem_ready, br_taken;
    logic        mem_req, mem_we, ir_we, pc_we, rf_we;
    logic [6:0]  imm_sel;
    logic        alu_a_pc, alu_b_imm;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic        halt;
    logic [1:0]  err;
`ifdef MC_INSTRET_EN
    logic [31:0] instret;
`endif

    mc_ctrl #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .ir(ir),
        .mem_ready(mem_ready), .br_taken(br_taken),
        .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .pc_we(pc_we), .rf_we(rf_we), .imm_sel(imm_sel),
        .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm),
        .pc_sel(pc_sel), .wb_sel(wb_sel), .state(state),
        .halt(halt), .err(err)
`ifdef MC_INSTRET_EN
       ,.instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [2:0]  st;
        logic [4:0]  en;
        logic [1:0]  ps;
        logic [1:0]  ws;
        logic [1:0]  alu;
        logic        h;
        logic [1:0]  e;
        logic [6:0]  isel;
        logic [31:0] ic;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [6:0]  op_q;
    logic [31:0] icnt;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t r;
        if (q.size() != 0) begin
            r = q.pop_front();
            chk(r.nm, "state", 32'(state), 32'(r.st));
            chk(r.nm, "en", 32'({mem_req, mem_we, ir_we, pc_we, rf_we}), 32'(r.en));
            chk(r.nm, "halt", 32'(halt), 32'(r.h));
            chk(r.nm, "err", 32'(err), 32'(r.e));
            chk(r.nm, "imm_sel", 32'(imm_sel), 32'(r.isel));
            if (r.en[1]) chk(r.nm, "pc_sel", 32'(pc_sel), 32'(r.ps));
            if (r.en[0]) chk(r.nm, "wb_sel", 32'(wb_sel), 32'(r.ws));
            if (r.st == 3'd2) chk(r.nm, "alu", 32'({alu_a_pc, alu_b_imm}), 32'(r.alu));
`ifdef MC_INSTRET_EN
            chk(r.nm, "instret", instret, r.ic);
`endif
        end
    end

    // en = {mem_req, mem_we, ir_we, pc_we, rf_we}
    task automatic step(input string nm, input logic mr, input logic bt,
                        input logic [2:0] st, input logic [4:0] en,
                        input logic [1:0] ps, input logic [1:0] ws,
                        input logic [1:0] alu, input logic h, input logic [1:0] e);
        exp_t r;
        r.nm = nm; r.st = st; r.en = en; r.ps = ps; r.ws = ws;
        r.alu = alu; r.h = h; r.e = e; r.isel = op_q; r.ic = icnt;
        mem_ready = mr;
        br_taken  = bt;
        q.push_back(r);
        if (en[1]) icnt = icnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst  = 1'b1;
        icnt = 32'd0;
        op_q = 7'd0;
        step(nm, 1'b1, 1'b1, 3'd0, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        rst = 1'b0;
    endtask

    task automatic fd(input string nm, input logic [31:0] instr, input int fw);
        ir = instr;
        for (int i = 0; i < fw; i++)
            step(nm, 1'b0, 1'b0, 3'd0, 5'b10000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        step(nm, 1'b1, 1'b0, 3'd0, 5'b10100, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        step(nm, 1'b1, 1'b0, 3'd1, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        op_q = instr[6:0];
    endtask

    task automatic wb_instr(input string nm, input logic [31:0] instr, input int fw,
                            input logic [1:0] alu, input logic [1:0] ps,
                            input logic [1:0] ws);
        fd(nm, instr, fw);
        step(nm, 1'b1, 1'b0, 3'd2, 5'b00000, 2'd0, 2'd0, alu, 1'b0, 2'd0);
        step(nm, 1'b1, 1'b0, 3'd4, 5'b00011, ps, ws, 2'd0, 1'b0, 2'd0);
    endtask

    initial begin
        rst = 1'b1; ir = 32'd0; mem_ready = 1'b0; br_taken = 1'b0;
        op_q = 7'd0; icnt = 32'd0;
        @(posedge clk);
        #1;
        do_reset("reset");

        wb_instr("addi", 32'h00500093, 0, 2'b01, 2'd0, 2'd0);

        fd("lw", 32'h0000A103, 0);
        step("lw", 1'b1, 1'b0, 3'd2, 5'b00000, 2'd0, 2'd0, 2'b01, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++)
            step("lw", 1'b0, 1'b0, 3'd3, 5'b10000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        step("lw", 1'b1, 1'b0, 3'd3, 5'b10000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        step("lw", 1'b1, 1'b0, 3'd4, 5'b00011, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0);

        fd("beq_t", 32'h00000463, 0);
        step("beq_t", 1'b1, 1'b1, 3'd2, 5'b00010, 2'd1, 2'd0, 2'b00, 1'b0, 2'd0);
        fd("beq_n", 32'h00000463, 0);
        step("beq_n", 1'b1, 1'b0, 3'd2, 5'b00010, 2'd0, 2'd0, 2'b00, 1'b0, 2'd0);

        wb_instr("jal",   32'h008000EF, 0, 2'b01, 2'd1, 2'd2);
        wb_instr("jalr",  32'h000080E7, 0, 2'b01, 2'd2, 2'd2);
        wb_instr("auipc", 32'h00001097, 0, 2'b11, 2'd0, 2'd0);
        wb_instr("lui",   32'h000010B7, 0, 2'b01, 2'd0, 2'd0);
        wb_instr("add",   32'h002081B3, 2, 2'b00, 2'd0, 2'd0);

        fd("sw", 32'h00112023, 0);
        step("sw", 1'b1, 1'b0, 3'd2, 5'b00000, 2'd0, 2'd0, 2'b01, 1'b0, 2'd0);
        step("sw", 1'b1, 1'b0, 3'd3, 5'b11010, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);

        // 15 wait cycles, ready on the limit cycle completes the fetch
        wb_instr("wait15", 32'h00500093, 15, 2'b01, 2'd0, 2'd0);

        fd("sw_rst", 32'h00112023, 0);
        step("sw_rst", 1'b1, 1'b0, 3'd2, 5'b00000, 2'd0, 2'd0, 2'b01, 1'b0, 2'd0);
        step("sw_rst", 1'b0, 1'b0, 3'd3, 5'b11000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        do_reset("sw_rst_abort");
        wb_instr("post_rst", 32'h00500093, 0, 2'b01, 2'd0, 2'd0);

        ir = 32'd0;
        for (int i = 0; i < 16; i++)
            step("tmo_wait", 1'b0, 1'b0, 3'd0, 5'b10000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++)
            step("tmo_halt", 1'b1, 1'b1, 3'd5, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2);
        do_reset("tmo_rst");
        step("tmo_fetch", 1'b0, 1'b0, 3'd0, 5'b10000, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0);

        fd("illegal", 32'hFFFFFFFF, 0);
        for (int i = 0; i < 21; i++)
            step("ill_halt", 1'b1, 1'b1, 3'd5, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1);
        do_reset("ill_rst");
        wb_instr("final", 32'h00500093, 0, 2'b01, 2'd0, 2'd0);

        for (int i = 0; i < 5 && q.size() != 0; i++)
            @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
